// File: rtl/mag_est_pipe_if.sv
// Streaming bus for mag_est_pipe: upstream sample handshake (in_*) and
// downstream result handshake (out_*). The slave modport is the estimator's
// view; the master modport is the environment that feeds and drains it.
interface mag_est_pipe_if #(
  parameter int W_IN  = 26,
  parameter int W_OUT = 27
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W_IN-1:0]  in_a;
  logic signed [W_IN-1:0]  in_b;
  logic [1:0]              in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [W_OUT-1:0]        out_mag;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_mag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_mag
  );
endinterface

// File: rtl/mag_est_pipe.sv
// mag_est_pipe: three-stage pipelined magnitude estimator for signed I/Q pairs.
//   S1: absolute values (most-negative input maps to 2^(W_IN-1) exactly)
//   S2: max/min ordering and L1 sum
//   S3: estimator law selected per sample by in_mode
//     00 |a|+|b|   01 mx+mn/2   10 mx+mn/4+mn/8   11 mx
// One global stall (result held, not taken) freezes every stage; otherwise
// all stages advance together and bubbles flow through.
// Optional feature macro: MAG_PEAK_HOLD_EN adds peak_clr/peak running-max
// tracking of transferred results.
module mag_est_pipe #(
  parameter int W_IN  = 26,
  parameter int W_OUT = 27
) (
  input  logic              clk,
  input  logic              rst,
  mag_est_pipe_if.slave     bus
`ifdef MAG_PEAK_HOLD_EN
  ,
  input  logic              peak_clr,
  output logic [W_OUT-1:0]  peak
`endif
);

  if (W_OUT < W_IN + 1) begin : g_width_check
    $error("mag_est_pipe: W_OUT must be at least W_IN+1");
  end

  logic stall;
  logic advance;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign advance      = ~stall;
  assign bus.in_ready = ~stall;

  // ---------------- stage 1: absolute values ----------------
  logic [W_IN-1:0] abs_a_c;
  logic [W_IN-1:0] abs_b_c;
  logic            v1;
  logic [W_IN-1:0] abs_a1;
  logic [W_IN-1:0] abs_b1;
  logic [1:0]      mode1;

  // Two's-complement negate in W_IN bits; -2^(W_IN-1) wraps to the unsigned
  // pattern 2^(W_IN-1), which is the correct magnitude.
  always_comb begin
    abs_a_c = bus.in_a[W_IN-1] ? W_IN'(-bus.in_a) : W_IN'(bus.in_a);
    abs_b_c = bus.in_b[W_IN-1] ? W_IN'(-bus.in_b) : W_IN'(bus.in_b);
  end

  // Stage 1 register: capture magnitudes and the sample's mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      abs_a1 <= '0;
      abs_b1 <= '0;
      mode1  <= 2'b00;
    end else if (advance) begin
      v1     <= bus.in_valid;
      abs_a1 <= abs_a_c;
      abs_b1 <= abs_b_c;
      mode1  <= bus.in_mode;
    end
  end

  // ---------------- stage 2: ordering and L1 ----------------
  logic            a_ge_b;
  logic            v2;
  logic [W_IN-1:0] mx2;
  logic [W_IN-1:0] mn2;
  logic [W_IN:0]   l1_2;
  logic [1:0]      mode2;

  // Ties resolve to mx=|a| (equal values, so only matters for clarity).
  assign a_ge_b = (abs_a1 >= abs_b1);

  // Stage 2 register: max, min and the full-width L1 sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      mx2   <= '0;
      mn2   <= '0;
      l1_2  <= '0;
      mode2 <= 2'b00;
    end else if (advance) begin
      v2    <= v1;
      mx2   <= a_ge_b ? abs_a1 : abs_b1;
      mn2   <= a_ge_b ? abs_b1 : abs_a1;
      l1_2  <= {1'b0, abs_a1} + {1'b0, abs_b1};
      mode2 <= mode1;
    end
  end

  // ---------------- stage 3: law selection ----------------
  logic [W_IN:0]    mx_ext;
  logic [W_IN:0]    mn_sh1;
  logic [W_IN:0]    mn_sh2;
  logic [W_IN:0]    mn_sh3;
  logic [W_IN:0]    est_c;
  logic [W_OUT-1:0] est_ext_c;

  // All laws fit in W_IN+1 bits because mn <= mx <= 2^(W_IN-1).
  always_comb begin
    mx_ext = {1'b0, mx2};
    mn_sh1 = {1'b0, mn2} >> 1;
    mn_sh2 = {1'b0, mn2} >> 2;
    mn_sh3 = {1'b0, mn2} >> 3;
    est_c  = l1_2;
    case (mode2)
      2'b00:   est_c = l1_2;
      2'b01:   est_c = mx_ext + mn_sh1;
      2'b10:   est_c = mx_ext + mn_sh2 + mn_sh3;
      default: est_c = mx_ext;
    endcase
    est_ext_c            = '0;
    est_ext_c[W_IN:0]    = est_c;
  end

  // Output register: out_mag only reloads on a real sample so it keeps the
  // last result through bubbles and is frozen during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_mag   <= '0;
    end else if (advance) begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.out_mag <= est_ext_c;
      end
    end
  end

`ifdef MAG_PEAK_HOLD_EN
  logic out_xfer;

  assign out_xfer = bus.out_valid & bus.out_ready;

  // Running maximum of transferred results; a clear restarts from the result
  // transferred in the same cycle, if any.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
    end else if (peak_clr) begin
      peak <= out_xfer ? bus.out_mag : '0;
    end else if (out_xfer && (bus.out_mag > peak)) begin
      peak <= bus.out_mag;
    end
  end
`endif

endmodule

// File: tb/tb_mag_est_pipe.sv
// Self-checking bench for mag_est_pipe: directed vector table, hand-written
// back-to-back / stall / mid-stream reset / peak sequences, then randomized
// traffic against an arithmetic reference model with an in-order scoreboard.
module tb_mag_est_pipe;
  localparam int W_IN  = 26;
  localparam int W_OUT = 27;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mag_est_pipe_if #(.W_IN(W_IN), .W_OUT(W_OUT)) bus ();

`ifdef MAG_PEAK_HOLD_EN
  logic             peak_clr;
  logic [W_OUT-1:0] peak;
`endif

  mag_est_pipe #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MAG_PEAK_HOLD_EN
    ,
    .peak_clr(peak_clr),
    .peak(peak)
`endif
  );

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    string  name;
    longint a;
    longint b;
    int     mode;
    longint exp;
  } vec_t;

  vec_t   vecs[10];
  longint exp_q[$];
  bit     sb_on = 0;
  bit     pk_on = 0;
  bit     hold_pend = 0;
  logic [W_OUT-1:0] hold_val;
  longint pk_model = 0;
  int     xfer_cnt = 0;
  int     acc_cnt = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: magnitude laws computed with plain integer arithmetic.
  function automatic longint model(input longint a, input longint b, input int mode);
    longint aa, bb, mx, mn;
    aa = (a < 0) ? -a : a;
    bb = (b < 0) ? -b : b;
    mx = (aa >= bb) ? aa : bb;
    mn = (aa >= bb) ? bb : aa;
    case (mode)
      0:       return aa + bb;
      1:       return mx + mn / 2;
      2:       return mx + mn / 4 + mn / 8;
      default: return mx;
    endcase
  endfunction

  function automatic longint rand_in();
    bit [31:0]              tmp;
    logic signed [W_IN-1:0] r;
    tmp = $urandom;
    r   = tmp[W_IN-1:0];
    case ($urandom % 8)
      0:       return -(longint'(1) << (W_IN - 1));
      1:       return (longint'(1) << (W_IN - 1)) - 1;
      2:       return 0;
      default: return r;
    endcase
  endfunction

  task automatic drive(input longint a, input longint b, input int mode);
    bus.in_a    = a[W_IN-1:0];
    bus.in_b    = b[W_IN-1:0];
    bus.in_mode = mode[1:0];
  endtask

  // One clock of scoreboarded traffic: inputs are already driven; sample the
  // handshakes at the falling edge, then move to just after the rising edge.
  task automatic step();
    bit xfer;
    @(negedge clk);
    xfer = bus.out_valid && bus.out_ready;
    if (sb_on) begin
      if (hold_pend) begin
        check("stall_hold_valid", bus.out_valid, 1);
        check("stall_hold_mag", bus.out_mag, hold_val);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_a, bus.in_b, int'(bus.in_mode)));
        acc_cnt++;
      end
      if (xfer) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else check("stream_mag", bus.out_mag, exp_q.pop_front());
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = bus.out_mag;
    end
`ifdef MAG_PEAK_HOLD_EN
    if (pk_on) begin
      check("peak_track", peak, pk_model);
      if (peak_clr) pk_model = xfer ? longint'(bus.out_mag) : 0;
      else if (xfer && longint'(bus.out_mag) > pk_model) pk_model = bus.out_mag;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  // Single isolated sample: checks 3-cycle latency and value; optionally
  // pulses peak_clr on the cycle the result transfers.
  task automatic run_vec(input string name, input longint a, input longint b,
                         input int mode, input longint exp, input bit clr);
    int lat;
    drive(a, b, mode);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    check({name, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_mag"}, bus.out_mag, exp);
`ifdef MAG_PEAK_HOLD_EN
    peak_clr = clr;
`endif
    @(posedge clk);
    #1;
`ifdef MAG_PEAK_HOLD_EN
    peak_clr = 1'b0;
`endif
    check({name, "_valid_drop"}, bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint got[$];
    int     n_out;
    longint last_mag;

    vecs[0] = '{"m00_small",    -5,        3,        0, 8};
    vecs[1] = '{"m00_mostneg",  -33554432, -33554432, 0, 67108864};
    vecs[2] = '{"m01_basic",    100,       -40,      1, 120};
    vecs[3] = '{"m10_basic",    100,       -40,      2, 115};
    vecs[4] = '{"m11_basic",    100,       -40,      3, 100};
    vecs[5] = '{"m00_zero",     0,         0,        0, 0};
    vecs[6] = '{"m11_mostneg",  -33554432, 33554431, 3, 33554432};
    vecs[7] = '{"m01_tie",      7,         -7,       1, 10};
    vecs[8] = '{"m10_trunc",    8,         7,        2, 9};
    vecs[9] = '{"m10_mostneg",  -33554432, -33554432, 2, 46137344};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0);
`ifdef MAG_PEAK_HOLD_EN
    peak_clr = 1'b0;
`endif
    #22;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_mag", bus.out_mag, 0);
`ifdef MAG_PEAK_HOLD_EN
    check("rst_peak", peak, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp, 1'b0);

    // Back-to-back, one sample per mode.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      drive(100, -40, m);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) got.push_back(bus.out_mag);
      @(posedge clk);
      #1;
    end
    check("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      check("b2b_0", got[0], 120);
      check("b2b_1", got[1], 115);
      check("b2b_2", got[2], 100);
    end

`ifdef MAG_PEAK_HOLD_EN
    bus.in_valid = 1'b0;
    peak_clr = 1'b1;
    @(posedge clk);
    #1;
    peak_clr = 1'b0;
    run_vec("pk_8",   -5,  3,   0, 8,   1'b0);
    run_vec("pk_120", 100, -40, 1, 120, 1'b0);
    run_vec("pk_50",  50,  0,   0, 50,  1'b0);
    check("peak_max", peak, 120);
    run_vec("pk_30",  30,  0,   3, 30,  1'b1);
    check("peak_clr_xfer", peak, 30);
`endif

    // Stall: in_valid held high, out_ready low for 6 clocks.
    sb_on = 1;
    acc_cnt = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(i * 1000 + 1, -(i * 3), i % 4);
      step();
    end
    check("stall_accepts", acc_cnt, 3);
    check("stall_in_ready", bus.in_ready, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    xfer_cnt = 0;
    for (int i = 0; i < 6; i++) step();
    check("stall_drain_count", xfer_cnt, 3);
    check("stall_drain_empty", exp_q.size(), 0);
    sb_on = 0;
    hold_pend = 0;

    // Mid-stream reset with two samples in flight.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(10, 1, 0);
    @(posedge clk);
    #1;
    drive(20, 2, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(3, -4, 0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_out = 0;
    last_mag = -1;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid) begin
        n_out++;
        last_mag = bus.out_mag;
      end
      @(posedge clk);
      #1;
    end
    check("midrst_out_count", n_out, 1);
    check("midrst_out_mag", last_mag, 7);

    // Randomized traffic against the reference model.
`ifdef MAG_PEAK_HOLD_EN
    peak_clr = 1'b1;
    @(posedge clk);
    #1;
    peak_clr = 1'b0;
    pk_model = 0;
    pk_on = 1;
`endif
    sb_on = 1;
    for (int i = 0; i < 500; i++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 4) != 0;
      drive(rand_in(), rand_in(), int'($urandom % 4));
`ifdef MAG_PEAK_HOLD_EN
      peak_clr = ($urandom % 16) == 0;
`endif
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
`ifdef MAG_PEAK_HOLD_EN
    peak_clr = 1'b0;
`endif
    for (int i = 0; i < 8; i++) step();
    check("rand_drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mag_est_pipe.md
Name: mag_est_pipe

Overview:
- Pipelined, mode-selectable magnitude estimator for signed I/Q sample pairs.
- Feeds the EMA/AGC power-tracking path.
- Replaces the combinational |a|+|b| adder with a registered 3-stage datapath.
- Adds valid/ready flow control, runtime selection of the estimator law, and optional peak tracking.

Parameters:
- W_IN, 26, width of each signed two's-complement input.
- W_OUT, 27, output width. Must be >= W_IN+1; elaborate-time error otherwise. Results are zero-extended to W_OUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_a  in  W_IN  signed I component
- in_b  in  W_IN  signed Q component
- in_mode  in  2  estimator law, sampled with the input
- out_valid  out  1  out_mag valid
- out_ready  in  1  downstream accepts
- out_mag  out  W_OUT  unsigned magnitude estimate
- peak_clr  in  1  (PEAK_HOLD_EN only) synchronous clear of peak
- peak  out  W_OUT  (PEAK_HOLD_EN only) running maximum of out_mag

Behaviour:
- Reset (async assert, sync release): all stage valids=0, out_valid=0, out_mag=0, peak=0. in_ready=1 from the first cycle after release.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall.
  - When not stalled, all three stages advance together and bubbles propagate.
  - When stalled, every stage register holds its value.
- Input accept: an input transfer occurs when in_valid & in_ready.
- Latency: exactly 3 clk from accept to out_valid when no stall occurs. Throughput is 1 sample/clk.
- Output transfer: a result is transferred when out_valid & out_ready. out_mag is stable while out_valid=1 and out_ready=0.
- S1: per input, abs into W_IN-bit unsigned: x if sign=0, else two's complement of x. Most-negative input -2^(W_IN-1) yields exactly 2^(W_IN-1) with no overflow. in_mode is registered alongside.
- S2: mx = max(|a|,|b|), mn = min(|a|,|b|). Ties: mx=|a|. Also register L1 sum = |a|+|b| at W_IN+1 bits.
- S3, by mode:
  - 00: L1 sum.
  - 01: mx + (mn>>1).
  - 10: mx + (mn>>2) + (mn>>3). Each shift truncates toward zero.
  - 11: mx (L-infinity).
  - All sums are computed at W_IN+1 bits; no overflow is possible. The result is zero-extended to W_OUT.
- Mode applies per sample. Changing in_mode between samples affects only later samples.
- Simultaneous accept and output transfer in the same cycle is legal and required for full rate.
- Mid-stream reset discards all in-flight samples. No output is produced for them.

Optional Feature:
- Macro: MAG_PEAK_HOLD_EN.
- Defined:
  - peak_clr and peak ports exist.
  - On each output transfer, peak <= max(peak, out_mag).
  - peak_clr=1 sets peak to 0 next cycle. If a transfer coincides with peak_clr, peak <= out_mag of that transfer (the clear takes priority over the old value).
  - Reset sets peak to 0.
- Undefined: the ports and register are absent; the datapath is otherwise identical.

Test Plan:
- Mode 00, a=-5, b=3, out_ready=1 -> out_mag=8, out_valid high exactly 3 clk after accept.
- Mode 00, a=b=-33554432 (most negative, W_IN=26) -> out_mag=67108864, no wrap.
- a=100, b=-40:
  - mode 01 -> 120
  - mode 10 -> 115
  - mode 11 -> 100
  - Send back-to-back, one per mode, -> outputs in order.
- Continuous in_valid with out_ready low for 6 clk -> at most 3 samples accepted, then in_ready=0. After out_ready=1, all samples appear in order with none lost or duplicated; out_mag is held constant during the stall.
- Assert rst with 2 samples in flight -> out_valid=0 immediately. After release, the next sample's result is the only output.
- MAG_PEAK_HOLD_EN: outputs 8, 120, 50 -> peak=120. Pulse peak_clr coincident with output 30 -> peak=30.
